// File: rtl/leiwand_uart.sv
// leiwand_uart: memory-mapped 8N1 UART for the leiwand_rv32 SoC data bus.
// The bus access is acknowledged one cycle after it is seen. Written bytes go into
// a TX FIFO and are serialised onto uart_tx. The receiver is built only when the
// macro LEIWAND_UART_RX_EN is defined.
// Ports:
//   clk, resetn     clock; synchronous active-low reset
//   valid, ready    bus request (already decoded) / one-cycle registered acknowledge
//   wen             write strobes; any nonzero value means a write
//   addr            byte offset; addr[3:2] selects DATA/STATUS/DIV/reserved
//   wdata, rdata    write data / registered read data (0 when ready=0)
//   uart_tx         serial out, idle high
//   uart_rx         serial in (used only with LEIWAND_UART_RX_EN)
module leiwand_uart #(
  parameter int unsigned TX_FIFO_DEPTH = 4,
  parameter logic [15:0] DEFAULT_DIV   = 16'd104
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  output logic        ready,
  input  logic [3:0]  wen,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int unsigned AW = $clog2(TX_FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // Bus decode: side effects happen on the edge that raises ready
  logic       acc_c, wr_c, rd_c, push_req_c, push_ok_c, stat_wr_c, rd_data_c;
  logic [1:0] sel_c;
  assign acc_c      = valid && !ready;
  assign wr_c       = acc_c && (wen != 4'b0);
  assign rd_c       = acc_c && (wen == 4'b0);
  assign sel_c      = addr[3:2];
  assign push_req_c = wr_c && (sel_c == 2'd0);
  assign stat_wr_c  = wr_c && (sel_c == 2'd1);
  assign rd_data_c  = rd_c && (sel_c == 2'd0);

  logic unused_bits;
  assign unused_bits = ^{wdata[31:16], addr[1:0]};

  logic [15:0] div;
  logic        tx_overflow;
  logic        rx_valid, rx_overrun, frame_err;
  logic [7:0]  rx_byte;

  // TX FIFO: extra pointer bit distinguishes full from empty
  logic [7:0]    fifo_mem [TX_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          tx_full, tx_empty, pop_c;
  logic [7:0]    fifo_head;
  assign tx_empty  = (wr_ptr == rd_ptr);
  assign tx_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok_c = push_req_c && !tx_full;
  assign fifo_head = fifo_mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok_c) fifo_mem[wr_ptr[AW-1:0]] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)     rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // TX shifter
  tx_state_t   tx_state, tx_state_n;
  logic [15:0] tx_timer, tx_timer_n;
  logic [2:0]  tx_idx, tx_idx_n;
  logic [7:0]  tx_shreg, tx_shreg_n;
  logic        uart_tx_n, tx_busy;
  assign tx_busy = (tx_state != TX_IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_state <= TX_IDLE;
      tx_timer <= '0;
      tx_idx   <= '0;
      tx_shreg <= '0;
      uart_tx  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_timer <= tx_timer_n;
      tx_idx   <= tx_idx_n;
      tx_shreg <= tx_shreg_n;
      uart_tx  <= uart_tx_n;
    end
  end

  // Every state lasts div clocks; div is re-read at each bit boundary
  always_comb begin
    tx_state_n = tx_state;
    tx_timer_n = tx_timer;
    tx_idx_n   = tx_idx;
    tx_shreg_n = tx_shreg;
    uart_tx_n  = uart_tx;
    pop_c      = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (!tx_empty) begin
          pop_c      = 1'b1;
          tx_state_n = TX_START;
          tx_timer_n = div - 16'd1;
          tx_shreg_n = fifo_head;
          uart_tx_n  = 1'b0;
        end
      end
      TX_START: begin
        if (tx_timer == 16'd0) begin
          tx_state_n = TX_DATA;
          tx_timer_n = div - 16'd1;
          tx_idx_n   = 3'd0;
          uart_tx_n  = tx_shreg[0];
        end else begin
          tx_timer_n = tx_timer - 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_timer == 16'd0) begin
          tx_timer_n = div - 16'd1;
          if (tx_idx == 3'd7) begin
            tx_state_n = TX_STOP;
            uart_tx_n  = 1'b1;
          end else begin
            tx_idx_n   = tx_idx + 3'd1;
            tx_shreg_n = {1'b0, tx_shreg[7:1]};
            uart_tx_n  = tx_shreg[1];
          end
        end else begin
          tx_timer_n = tx_timer - 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_timer == 16'd0) begin
          if (!tx_empty) begin
            // back-to-back frame, no idle gap
            pop_c      = 1'b1;
            tx_state_n = TX_START;
            tx_timer_n = div - 16'd1;
            tx_shreg_n = fifo_head;
            uart_tx_n  = 1'b0;
          end else begin
            tx_state_n = TX_IDLE;
            uart_tx_n  = 1'b1;
          end
        end else begin
          tx_timer_n = tx_timer - 16'd1;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

`ifdef LEIWAND_UART_RX_EN
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic        rx_s1, rx_s2, rx_prev;
  rx_state_t   rx_state, rx_state_n;
  logic [15:0] rx_timer, rx_timer_n;
  logic [2:0]  rx_idx, rx_idx_n;
  logic [7:0]  rx_shreg, rx_shreg_n;
  logic        rx_done_c, rx_ferr_c;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_timer <= '0;
      rx_idx   <= '0;
      rx_shreg <= '0;
    end else begin
      rx_s1    <= uart_rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_state_n;
      rx_timer <= rx_timer_n;
      rx_idx   <= rx_idx_n;
      rx_shreg <= rx_shreg_n;
    end
  end

  // Half a bit after the falling edge re-checks the start bit, then samples at centres
  always_comb begin
    rx_state_n = rx_state;
    rx_timer_n = rx_timer;
    rx_idx_n   = rx_idx;
    rx_shreg_n = rx_shreg;
    rx_done_c  = 1'b0;
    rx_ferr_c  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_s2) begin
          rx_state_n = RX_START;
          rx_timer_n = (div >> 1) - 16'd1;
        end
      end
      RX_START: begin
        if (rx_timer == 16'd0) begin
          if (rx_s2) begin
            rx_state_n = RX_IDLE;
          end else begin
            rx_state_n = RX_DATA;
            rx_timer_n = div - 16'd1;
            rx_idx_n   = 3'd0;
          end
        end else begin
          rx_timer_n = rx_timer - 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_timer == 16'd0) begin
          rx_shreg_n = {rx_s2, rx_shreg[7:1]};
          rx_timer_n = div - 16'd1;
          if (rx_idx == 3'd7) rx_state_n = RX_STOP;
          else                rx_idx_n   = rx_idx + 3'd1;
        end else begin
          rx_timer_n = rx_timer - 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_timer == 16'd0) begin
          rx_state_n = RX_IDLE;
          if (rx_s2) rx_done_c = 1'b1;
          else       rx_ferr_c = 1'b1;
        end else begin
          rx_timer_n = rx_timer - 16'd1;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // A landing byte wins over a same-edge read clear and is then not an overrun
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_byte    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (rx_done_c) begin
        rx_byte  <= rx_shreg;
        rx_valid <= 1'b1;
      end else if (rd_data_c) begin
        rx_valid <= 1'b0;
      end
      if (rx_done_c && rx_valid && !rd_data_c) rx_overrun <= 1'b1;
      else if (stat_wr_c && wdata[4])          rx_overrun <= 1'b0;
      if (rx_ferr_c)                  frame_err <= 1'b1;
      else if (stat_wr_c && wdata[5]) frame_err <= 1'b0;
    end
  end
`else
  logic unused_rx;
  assign unused_rx  = uart_rx;
  assign rx_byte    = 8'd0;
  assign rx_valid   = 1'b0;
  assign rx_overrun = 1'b0;
  assign frame_err  = 1'b0;
`endif

  // Read mux
  logic [31:0] rd_val_c;
  always_comb begin
    rd_val_c = '0;
    case (sel_c)
      2'd0: rd_val_c = rx_valid ? {24'd0, rx_byte} : 32'd0;
      2'd1: rd_val_c = {25'd0, tx_overflow, frame_err, rx_overrun, rx_valid,
                        tx_busy, tx_empty, tx_full};
      2'd2: rd_val_c = {16'd0, div};
      default: rd_val_c = '0;
    endcase
  end

  // Bus registers, divider and TX overflow flag (overflow set wins over clear)
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready       <= 1'b0;
      rdata       <= '0;
      div         <= DEFAULT_DIV;
      tx_overflow <= 1'b0;
    end else begin
      ready <= acc_c;
      rdata <= rd_c ? rd_val_c : 32'd0;
      if (wr_c && (sel_c == 2'd2))
        div <= (wdata[15:0] < 16'd2) ? 16'd2 : wdata[15:0];
      if (push_req_c && tx_full)      tx_overflow <= 1'b1;
      else if (stat_wr_c && wdata[6]) tx_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_leiwand_uart.sv
// Directed bench for leiwand_uart: bus handshake, register map, TX framing,
// back-to-back frames with FIFO overflow, divider clamp, reset mid-frame and,
// when LEIWAND_UART_RX_EN is defined, the receiver.
module tb_leiwand_uart;

  logic        clk = 1'b0;
  logic        resetn, valid, ready, uart_tx, uart_rx;
  logic [3:0]  wen, addr;
  logic [31:0] wdata, rdata;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  leiwand_uart dut (
    .clk(clk), .resetn(resetn), .valid(valid), .ready(ready), .wen(wen),
    .addr(addr), .wdata(wdata), .rdata(rdata), .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  // uart_tx waveform recorder, one sample per falling clock edge
  logic rec_buf [0:8191];
  int   rec_n = 0;
  always @(negedge clk) begin
    if (rec_n < 8192) begin
      rec_buf[rec_n] <= uart_tx;
      rec_n <= rec_n + 1;
    end
  end

  task automatic wait_rec(input int target);
    int g = 0;
    while (rec_n < target && g < 4000) begin
      @(posedge clk);
      g++;
    end
  endtask

  // 8N1 line level k clocks into a frame of byte b at d clocks per bit
  function automatic logic frame_bit(input logic [7:0] b, input int d, input int k);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    return fr[k / d];
  endfunction

  task automatic bus(input logic we, input logic [3:0] a, input logic [31:0] d,
                     output logic [31:0] rd);
    int n = 0;
    @(negedge clk);
    valid = 1'b1; wen = we ? 4'hF : 4'h0; addr = a; wdata = d;
    do begin
      @(posedge clk); #1; n++;
    end while (!ready && n < 8);
    total++;
    if (!ready) begin
      bad++;
      $display("FAIL bus_ack addr=%h: ready=%b after %0d cycles, required 1", a, ready, n);
    end
    rd = rdata;
    valid = 1'b0; wen = 4'h0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus(1'b1, a, d, dummy);
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    bus(1'b0, a, 32'd0, d);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input int d);
    @(negedge clk); uart_rx = 1'b0;
    repeat (d) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (d) @(negedge clk);
    end
    uart_rx = stop;
    repeat (d) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * d) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] r;
    resetn = 1'b0; valid = 1'b0; wen = 4'h0; addr = 4'h0; wdata = 32'd0; uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", ready); end
    total++; if (rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata: got %h want 0", rdata); end
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL rst_tx: got %b want 1", uart_tx); end
    @(negedge clk); resetn = 1'b1;
    // Held valid: ack after one edge, then low on the next
    @(negedge clk); valid = 1'b1; wen = 4'h0; addr = 4'h4;
    @(posedge clk); #1;
    total++; if (ready !== 1'b1 || rdata !== 32'h2) begin
      bad++; $display("FAIL ack_first: ready=%b rdata=%h want 1/00000002", ready, rdata); end
    @(posedge clk); #1;
    total++; if (ready !== 1'b0 || rdata !== 32'h0) begin
      bad++; $display("FAIL ack_held: ready=%b rdata=%h want 0/00000000", ready, rdata); end
    valid = 1'b0;
    rd(4'h8, r);
    total++; if (r !== 32'h68) begin bad++; $display("FAIL rst_div: got %h want 00000068", r); end
    rd(4'hC, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL resv_read: got %h want 0", r); end
    wr(4'hC, 32'hFFFF_FFFF);
    rd(4'h4, r);
    total++; if (r !== 32'h2) begin bad++; $display("FAIL resv_write_status: got %h want 00000002", r); end
  endtask

  task automatic test_tx_single();
    logic [31:0] r;
    int base;
    wr(4'h8, 32'd4);
    wr(4'h0, 32'h55);
    base = rec_n;
    rd(4'h4, r);
    total++; if (r !== 32'h6) begin bad++; $display("FAIL tx1_busy: status=%h want 00000006", r); end
    wait_rec(base + 45);
    total++; if (rec_buf[base] !== 1'b1) begin bad++; $display("FAIL tx1_pre: got %b want 1", rec_buf[base]); end
    for (int k = 0; k < 44; k++) begin
      logic e;
      e = (k < 40) ? frame_bit(8'h55, 4, k) : 1'b1;
      total++;
      if (rec_buf[base + 1 + k] !== e) begin
        bad++; $display("FAIL tx1_wave[%0d]: got %b want %b", k, rec_buf[base + 1 + k], e);
      end
    end
    rd(4'h4, r);
    total++; if (r !== 32'h2) begin bad++; $display("FAIL tx1_done: status=%h want 00000002", r); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic [7:0]  bs [5];
    int base;
    for (int i = 0; i < 5; i++) bs[i] = 8'(i + 1);
    // The first byte leaves the FIFO on the edge after its push, so the sixth write overflows
    wr(4'h0, 32'h01);
    base = rec_n;
    for (int i = 2; i <= 6; i++) wr(4'h0, 32'(i));
    wait_rec(base + 1 + 200 + 6);
    total++; if (rec_buf[base] !== 1'b1) begin bad++; $display("FAIL b2b_pre: got %b want 1", rec_buf[base]); end
    for (int k = 0; k < 206; k++) begin
      logic e;
      e = (k < 200) ? frame_bit(bs[k / 40], 4, k % 40) : 1'b1;
      total++;
      if (rec_buf[base + 1 + k] !== e) begin
        bad++; $display("FAIL b2b_wave[%0d]: got %b want %b", k, rec_buf[base + 1 + k], e);
      end
    end
    rd(4'h4, r);
    total++; if (r !== 32'h42) begin bad++; $display("FAIL b2b_ovf: status=%h want 00000042", r); end
    wr(4'h4, 32'h40);
    rd(4'h4, r);
    total++; if (r !== 32'h2) begin bad++; $display("FAIL b2b_w1c: status=%h want 00000002", r); end
  endtask

  task automatic test_div_clamp();
    logic [31:0] r;
    int base;
    wr(4'h8, 32'd3);
    rd(4'h8, r);
    total++; if (r !== 32'h3) begin bad++; $display("FAIL div3: got %h want 00000003", r); end
    wr(4'h8, 32'd1);
    rd(4'h8, r);
    total++; if (r !== 32'h2) begin bad++; $display("FAIL div1_clamp: got %h want 00000002", r); end
    wr(4'h8, 32'h0001_0000);
    rd(4'h8, r);
    total++; if (r !== 32'h2) begin bad++; $display("FAIL div0_clamp: got %h want 00000002", r); end
    wr(4'h0, 32'hC3);
    base = rec_n;
    wait_rec(base + 1 + 24);
    for (int k = 0; k < 24; k++) begin
      logic e;
      e = (k < 20) ? frame_bit(8'hC3, 2, k) : 1'b1;
      total++;
      if (rec_buf[base + 1 + k] !== e) begin
        bad++; $display("FAIL div2_wave[%0d]: got %b want %b", k, rec_buf[base + 1 + k], e);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] r;
    wr(4'h8, 32'd4);
    wr(4'h0, 32'hA5);
    // 10 edges after the ack the line is inside data bit 1 (a 0)
    repeat (10) @(posedge clk);
    #1;
    total++; if (uart_tx !== 1'b0) begin bad++; $display("FAIL midf_pre: got %b want 0", uart_tx); end
    resetn = 1'b0;
    @(posedge clk); #1;
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL midf_rst_tx: got %b want 1", uart_tx); end
    @(negedge clk); resetn = 1'b1;
    rd(4'h4, r);
    total++; if (r !== 32'h2) begin bad++; $display("FAIL midf_status: got %h want 00000002", r); end
    rd(4'h8, r);
    total++; if (r !== 32'h68) begin bad++; $display("FAIL midf_div: got %h want 00000068", r); end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      total++;
      if (uart_tx !== 1'b1) begin bad++; $display("FAIL midf_idle[%0d]: got %b want 1", i, uart_tx); end
    end
  endtask

  task automatic test_rx();
    logic [31:0] r;
    wr(4'h8, 32'd8);
`ifdef LEIWAND_UART_RX_EN
    send_rx(8'h3C, 1'b1, 8);
    rd(4'h4, r);
    total++; if (r !== 32'h0A) begin bad++; $display("FAIL rx_valid: status=%h want 0000000a", r); end
    rd(4'h0, r);
    total++; if (r !== 32'h3C) begin bad++; $display("FAIL rx_data: got %h want 0000003c", r); end
    rd(4'h4, r);
    total++; if (r !== 32'h02) begin bad++; $display("FAIL rx_clear: status=%h want 00000002", r); end
    rd(4'h0, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL rx_empty_read: got %h want 0", r); end
    send_rx(8'h3C, 1'b0, 8);
    rd(4'h4, r);
    total++; if (r !== 32'h22) begin bad++; $display("FAIL rx_frame_err: status=%h want 00000022", r); end
    wr(4'h4, 32'h20);
    send_rx(8'h3C, 1'b1, 8);
    send_rx(8'hA7, 1'b1, 8);
    rd(4'h4, r);
    total++; if (r !== 32'h1A) begin bad++; $display("FAIL rx_overrun: status=%h want 0000001a", r); end
    rd(4'h0, r);
    total++; if (r !== 32'hA7) begin bad++; $display("FAIL rx_overwrite: got %h want 000000a7", r); end
    wr(4'h4, 32'h10);
    // two-clock low glitch is rejected at the half-bit re-check
    @(negedge clk); uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (30) @(negedge clk);
    rd(4'h4, r);
    total++; if (r !== 32'h02) begin bad++; $display("FAIL rx_glitch: status=%h want 00000002", r); end
`else
    send_rx(8'h3C, 1'b1, 8);
    rd(4'h4, r);
    total++; if (r !== 32'h02) begin bad++; $display("FAIL norx_status: got %h want 00000002", r); end
    rd(4'h0, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL norx_data: got %h want 0", r); end
`endif
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_back_to_back();
    test_div_clamp();
    test_reset_mid_frame();
    test_rx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
